// File: rtl/run_detect.sv
// Serial run-length detector: counts consecutive hits of a selectable polarity
// and raises a Mealy match output in ONCE, REPEAT or LEVEL mode.
module run_detect #(
  parameter int CNT_W  = 4,
  parameter int MCNT_W = 8
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              vld,
  input  logic              din,
  input  logic              pol,
  input  logic [CNT_W-1:0]  thr,
  input  logic [1:0]        mode,
  input  logic              cnt_clr,
  output logic              dout,
  output logic [CNT_W-1:0]  run_len,
  output logic [MCNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    M_ONCE   = 2'd0,
    M_REPEAT = 2'd1,
    M_LEVEL  = 2'd2,
    M_RSVD   = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0]  CMAX = '1;
  localparam logic [CNT_W-1:0]  CONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MCNT_W-1:0] MMAX = '1;
  localparam logic [MCNT_W-1:0] MONE = {{(MCNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc_c(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? CMAX : v + CONE;
  endfunction

  function automatic logic [MCNT_W-1:0] sat_inc_m(input logic [MCNT_W-1:0] v);
    return (v == MMAX) ? MMAX : v + MONE;
  endfunction

  logic [CNT_W-1:0]  run_q, run_d, ph_q, ph_d, thr_m1;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              hit, miss, en, fire_once, fire_rep, fire_lvl;

  always_comb begin
    hit       = vld & (din == pol);
    miss      = vld & (din != pol);
    thr_m1    = thr - CONE;
    en        = hit & ~rst & (thr != '0);
    fire_once = en & (run_q == thr_m1);
    fire_rep  = en & (ph_q == thr_m1);
    fire_lvl  = en & (run_q >= thr_m1);

    dout = 1'b0;
    case (mode_e'(mode))
      M_ONCE:   dout = fire_once;
      M_REPEAT: dout = fire_rep;
      M_LEVEL:  dout = fire_lvl;
      default:  dout = 1'b0;
    endcase

    // ph tracks the repeat phase in every mode so a live switch to REPEAT
    // lines up with the hits already seen in the current run.
    run_d = run_q;
    ph_d  = ph_q;
    if (hit) begin
      run_d = sat_inc_c(run_q);
      ph_d  = fire_rep ? '0 : sat_inc_c(ph_q);
    end else if (miss) begin
      run_d = '0;
      ph_d  = '0;
    end

    mcnt_d = mcnt_q;
    if (cnt_clr)   mcnt_d = '0;
    else if (dout) mcnt_d = sat_inc_m(mcnt_q);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      run_q  <= '0;
      ph_q   <= '0;
      mcnt_q <= '0;
    end else begin
      run_q  <= run_d;
      ph_q   <= ph_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign run_len   = run_q;
  assign match_cnt = mcnt_q;

endmodule
